// File: rtl/input_cond_pkg.sv
// Shared types and constants for the button/switch input conditioner.
// Holds the debounce state encoding, counter widths and the tick divider derivation.
package input_cond_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_t;

    // 16 bits covers TICK_DIV up to 65535, i.e. clocks up to 65 MHz.
    localparam int TICK_CNT_W = 16;
    localparam int DB_CNT_W   = 8;
    localparam int LONG_CNT_W = 10;

    localparam int NUM_BUTTONS  = 2;
    localparam int NUM_SWITCHES = 8;
    localparam int NUM_INPUTS   = NUM_BUTTONS + NUM_SWITCHES;

    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// Single-bit debouncer: STABLE/PENDING FSM clocked by the shared 1 ms tick.
// Emits registered level, rise/fall pulses and a sticky "accepted" flag.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_50m,
    input  logic reset,
    input  logic sync,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accepted
);

    localparam logic [DB_CNT_W-1:0] DB_LIMIT = DB_CNT_W'(DEBOUNCE_MS);

    db_state_t             state_q, state_d;
    logic                  level_q, level_d;
    logic [DB_CNT_W-1:0]   cnt_q,   cnt_d;
    logic                  first_q, first_d;
    logic                  rise_q,  rise_d;
    logic                  fall_q,  fall_d;
    logic [DB_CNT_W-1:0]   cnt_inc;

    assign cnt_inc = cnt_q + DB_CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state_q <= STABLE;
            level_q <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            STABLE: begin
                if (sync != level_q) begin
                    // A tick in this same cycle is deliberately not counted.
                    state_d = PENDING;
                    cnt_d   = '0;
                end else if (first_q && tick) begin
                    // Until first acceptance, count how long the reset level has held.
                    if (cnt_inc == DB_LIMIT) begin
                        first_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            PENDING: begin
                if (sync == level_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_inc == DB_LIMIT) begin
                        state_d = STABLE;
                        level_d = sync;
                        rise_d  = sync;
                        fall_d  = ~sync;
                        first_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level    = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign accepted = ~first_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: 2-flop sync, 1 ms tick, per-bit debounce, switch aggregation.
// Optional long-press detection is compiled in with INPUT_COND_LONG_PRESS_EN.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic                    clk_50m,
    input  logic                    reset,
    input  logic [NUM_BUTTONS-1:0]  button_raw,
    input  logic [NUM_SWITCHES-1:0] switch_raw,
    output logic [NUM_BUTTONS-1:0]  button_level,
    output logic [NUM_BUTTONS-1:0]  button_press,
    output logic [NUM_BUTTONS-1:0]  button_release,
    output logic [NUM_BUTTONS-1:0]  button_long,
    output logic [NUM_SWITCHES-1:0] switch_level,
    output logic                    switch_change,
    output logic                    switch_valid
);

    localparam int                    TICK_DIV  = tick_div(CLK_HZ);
    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICK_DIV - 1);

    logic [TICK_CNT_W-1:0] prescale_q;
    logic                  tick;

    logic [NUM_INPUTS-1:0] raw_all;
    logic [NUM_INPUTS-1:0] sync_meta_q;
    logic [NUM_INPUTS-1:0] sync_q;

    logic [NUM_INPUTS-1:0] level_all;
    logic [NUM_INPUTS-1:0] rise_all;
    logic [NUM_INPUTS-1:0] fall_all;
    logic [NUM_INPUTS-1:0] accepted_all;

    logic                  switch_valid_q;
    logic                  switch_change_q;
    logic [NUM_BUTTONS-1:0] unused_button_accepted;

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
        end else if (prescale_q == TICK_LAST) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + TICK_CNT_W'(1);
        end
    end

    assign tick = (prescale_q == TICK_LAST);

    // Buttons occupy the low bits, switches the upper bits of the shared vectors.
    assign raw_all = {switch_raw, button_raw};

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= raw_all;
            sync_q      <= sync_meta_q;
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_debounce_bit (
            .clk_50m  (clk_50m),
            .reset    (reset),
            .sync     (sync_q[i]),
            .tick     (tick),
            .level    (level_all[i]),
            .rise     (rise_all[i]),
            .fall     (fall_all[i]),
            .accepted (accepted_all[i])
        );
    end

    assign unused_button_accepted = accepted_all[NUM_BUTTONS-1:0];

    // The acceptance that completes the valid set is seen while valid_q is still low,
    // so it never produces a change pulse.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            switch_valid_q  <= 1'b0;
            switch_change_q <= 1'b0;
        end else begin
            switch_valid_q  <= switch_valid_q | (&accepted_all[NUM_INPUTS-1:NUM_BUTTONS]);
            switch_change_q <= switch_valid_q &
                               (|(rise_all[NUM_INPUTS-1:NUM_BUTTONS] |
                                  fall_all[NUM_INPUTS-1:NUM_BUTTONS]));
        end
    end

`ifdef INPUT_COND_LONG_PRESS_EN
    localparam logic [LONG_CNT_W-1:0] LONG_LIMIT = LONG_CNT_W'(LONG_MS);
    localparam logic [LONG_CNT_W-1:0] LONG_PRE   = LONG_CNT_W'(LONG_MS - 1);

    logic [NUM_BUTTONS-1:0][LONG_CNT_W-1:0] hold_cnt_q;
    logic [NUM_BUTTONS-1:0]                 long_q;

    // NOTE: the hold counters are a small packed array of flops, so they are reset
    // like any other state; large RAM-style arrays would be left unreset instead.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
            long_q     <= '0;
        end else begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                long_q[b] <= 1'b0;
                if (!level_all[b]) begin
                    hold_cnt_q[b] <= '0;
                end else if (tick && (hold_cnt_q[b] != LONG_LIMIT)) begin
                    // Saturating at LONG_LIMIT suppresses repeats until release.
                    hold_cnt_q[b] <= hold_cnt_q[b] + LONG_CNT_W'(1);
                    long_q[b]     <= (hold_cnt_q[b] == LONG_PRE);
                end
            end
        end
    end

    assign button_long = long_q;
`else
    logic [LONG_CNT_W-1:0] unused_long_ms;
    assign unused_long_ms = LONG_CNT_W'(LONG_MS);
    assign button_long    = '0;
`endif

    assign button_level   = level_all[NUM_BUTTONS-1:0];
    assign button_press   = rise_all[NUM_BUTTONS-1:0];
    assign button_release = fall_all[NUM_BUTTONS-1:0];
    assign switch_level   = level_all[NUM_INPUTS-1:NUM_BUTTONS];
    assign switch_change  = switch_change_q;
    assign switch_valid   = switch_valid_q;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage between the board's raw `button[1:0]`/`switch[7:0]` pins and the display/LED logic.
- Synchronizes every input to `clk_50m` and debounces each bit against a shared 1 ms tick.
- Presents clean levels plus single-cycle press/release/change pulses.
- Downstream pause, reset-request, display and LED logic consumes only these conditioned signals, never raw pins.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency; must be a multiple of 1000.
- `DEBOUNCE_MS`, 20, ticks an input must stay stable before its level is accepted; range 1..255.
- `LONG_MS`, 1000, hold time for a long press; only used when long press is compiled in.

Ports:
- `clk_50m` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `button_raw` input 2: raw push buttons, active-high.
- `switch_raw` input 8: raw DIP switches.
- `button_level` output 2: debounced button state.
- `button_press` output 2: one-cycle pulse on a debounced 0→1 transition.
- `button_release` output 2: one-cycle pulse on a debounced 1→0 transition.
- `button_long` output 2: one-cycle long-press pulse.
- `switch_level` output 8: debounced switch state.
- `switch_change` output 1: one-cycle pulse when any `switch_level` bit changes.
- `switch_valid` output 1: high once every switch has been accepted after reset.

## Operation
- Synchronization: two-flop synchronizer per input bit; the second flop feeds the debouncer as `sync`.
- Tick: a prescaler counts 0..TICK_DIV-1 and wraps, where TICK_DIV = CLK_HZ/1000. `tick` is a one-cycle pulse at the wrap. All bits share this tick.
- Per-bit FSM, with registered `level`, counter `cnt` (8 bits) and `first` flag:
  - STABLE: if sync ≠ level, go to PENDING and set cnt = 0. Otherwise stay.
  - PENDING: if sync = level, return to STABLE and clear cnt (glitch rejected, no pulse). Otherwise cnt increments on each tick.
  - Acceptance: on the tick where cnt would reach DEBOUNCE_MS, set level ← sync, emit the edge pulse, and return to STABLE.
  - A sync change and a tick in the same cycle: evaluate the comparison first; the tick does not count toward the new PENDING period.
- Button pulses:
  - `button_press` / `button_release` are asserted in the same cycle `button_level` updates, for exactly one cycle.
  - Both pulses are never high together for one bit.
- Switches:
  - Each switch bit's level resets to 0 and uses the same FSM.
  - `switch_valid` rises when every switch bit has either been accepted once or has been continuously equal to its reset level for DEBOUNCE_MS ticks. It then stays high until reset.
  - `switch_change` is the OR of per-bit acceptance events, gated by `switch_valid` already being high. The event that makes `switch_valid` rise does not pulse.
  - Several bits accepting in the same cycle produce one pulse.
- Reset values: `button_level`, `button_press`, `button_release`, `button_long`, `switch_level`, `switch_change` and `switch_valid` are all 0. Prescaler, counters and synchronizers are cleared, and every FSM is in STABLE.
- Reset mid-operation: all state clears immediately. A pending debounce is discarded and restarts from scratch after reset is released.

## Timing
- Raw-to-sync latency: 2 cycles.
- A sync change accepted after being held stable: `level` updates between (DEBOUNCE_MS−1)·TICK_DIV+1 and DEBOUNCE_MS·TICK_DIV cycles after PENDING is entered. The range reflects tick phase.
- Glitches shorter than one full debounce window never reach any output.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `INPUT_COND_LONG_PRESS_EN` defined:
  - Each button gets a 10-bit hold counter. It clears when `button_level` is 0 and increments on tick while `button_level` is 1.
  - When the counter reaches LONG_MS, `button_long` pulses for one cycle and the counter saturates, so there is no repeat until release.
  - A release before LONG_MS produces no long pulse.
- Macro undefined: hold counters are absent and `button_long` is tied to 0. The port list is unchanged.

## Structure
- Package `input_cond_pkg` holds:
  - the state enum {STABLE, PENDING};
  - the TICK_DIV derivation function;
  - the counter width constants (tick prescaler, debounce cnt 8 bits, long-press counter 10 bits).
- Sub-module `debounce_bit` (sync, tick → level, rise, fall, accepted) contains the FSM.
- `debounce_bit` is instantiated 10 times: 2 buttons and 8 switches.
- Prescaler, `switch_valid`/`switch_change` aggregation and the long-press counters live in the top.

## Test plan
Bench parameters: CLK_HZ=10_000 (TICK_DIV=10), DEBOUNCE_MS=4, LONG_MS=8.
- Reset then idle:
  - all outputs stay 0;
  - `switch_valid` rises within 40 cycles with `switch_change` never pulsing.
- `button_raw[0]` held high: `button_level[0]` rises within 32–40 cycles after sync; `button_press[0]` is high for exactly that one cycle.
- Bounce rejection: toggle `button_raw[1]` every 15 cycles for 200 cycles → no pulses and `button_level[1]` stays 0.
- Switch set: `switch_raw`=8'hA5 held after `switch_valid` → `switch_level`=8'hA5 and one single `switch_change` pulse.
- Reset mid-operation: `reset` asserted 20 cycles into a press → outputs clear immediately; after release a full 32–40-cycle window is needed again.
- Long press, macro defined: hold `button_raw[0]` for 150 cycles → `button_long[0]` pulses once about 80 cycles after `button_level[0]` rises. With the macro undefined, `button_long` is always 0.
